// File: rtl/serial_alu_seq.sv
// ---------------------------------------------------------------------------
// serial_alu_seq
// Bit-serial ALU. One result bit is produced per clock, LSB first, through a
// single 1-bit slice (AND / OR / full adder) with a registered carry.
// An operation takes WIDTH cycles from the accepting start edge to the cycle
// in which done pulses.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 2)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     begin an operation (sampled only while idle)
//   in1, in2  operands, captured when start is accepted
//   carryin   carry into bit 0 for ADD, captured when start is accepted
//   control   opcode: 00 AND, 01 OR, 10 ADD, 11 SUB (in1 - in2)
//   busy      high while bits are being computed
//   done      one-cycle pulse when the result is published
//   result    last completed result (held between operations)
//   carryout  carry out of the MSB for ADD/SUB (1 = no borrow for SUB), 0 otherwise
//   zero      high when result == 0
// ---------------------------------------------------------------------------
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carryin,
   input  logic [1:0]       control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] a_q,        a_d;
   logic [WIDTH-1:0] b_q,        b_d;
   logic [WIDTH-1:0] acc_q,      acc_d;
   logic [1:0]       op_q,       op_d;
   logic             carry_q,    carry_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic             carryout_q, carryout_d;
   logic             zero_q,     zero_d;

   // Slice signals
   logic slice_a;
   logic slice_b;
   logic slice_bit;
   logic slice_carry;
   logic is_arith;

   // Single 1-bit slice operating on the current LSBs of the shift registers
   always_comb begin
      slice_a     = a_q[0];
      // SUB adds the inverted subtrahend; the +1 comes from the preset carry
      slice_b     = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
      slice_bit   = 1'b0;
      slice_carry = carry_q;
      is_arith    = 1'b0;
      case (op_q)
         OP_AND: begin
            slice_bit   = slice_a & slice_b;
            slice_carry = carry_q;
         end
         OP_OR: begin
            slice_bit   = slice_a | slice_b;
            slice_carry = carry_q;
         end
         OP_ADD, OP_SUB: begin
            slice_bit   = slice_a ^ slice_b ^ carry_q;
            slice_carry = (slice_a & slice_b) | (carry_q & (slice_a ^ slice_b));
            is_arith    = 1'b1;
         end
         default: begin
            slice_bit   = 1'b0;
            slice_carry = carry_q;
            is_arith    = 1'b0;
         end
      endcase
   end

   // Next-state and datapath control for the IDLE/RUN/DONE sequencer
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      op_d       = op_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      carryout_d = carryout_q;
      zero_d     = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = in1;
               b_d     = in2;
               op_d    = control;
               acc_d   = {WIDTH{1'b0}};
               cnt_d   = {CW{1'b0}};
               case (control)
                  OP_ADD:  carry_d = carryin;
                  OP_SUB:  carry_d = 1'b1;
                  default: carry_d = 1'b0;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            // Partial result fills from the MSB side so bit 0 lands at the LSB
            acc_d   = {slice_bit, acc_q[WIDTH-1:1]};
            carry_d = slice_carry;
            if (cnt_q == LAST_BIT) begin
               // Counter parks on the last index instead of wrapping
               cnt_d      = cnt_q;
               state_d    = S_DONE;
               result_d   = {slice_bit, acc_q[WIDTH-1:1]};
               carryout_d = is_arith ? slice_carry : 1'b0;
               zero_d     = ({slice_bit, acc_q[WIDTH-1:1]} == {WIDTH{1'b0}});
            end else begin
               cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and published-output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         acc_q      <= {WIDTH{1'b0}};
         op_q       <= 2'b00;
         carry_q    <= 1'b0;
         cnt_q      <= {CW{1'b0}};
         result_q   <= {WIDTH{1'b0}};
         carryout_q <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         op_q       <= op_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
         zero_q     <= zero_d;
      end
   end

   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign carryout = carryout_q;
   assign zero     = zero_q;

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be at least 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: in1  input  WIDTH  operand A; captured on accepted start.
REQ-006 Port: in2  input  WIDTH  operand B; captured on accepted start.
REQ-007 Port: carryin  input  1  carry into bit 0 for ADD; captured on accepted start.
REQ-008 Port: control  input  2  opcode (00 AND, 01 OR, 10 ADD, 11 SUB); captured on accepted start.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse, high only in DONE.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: carryout  output  1  carry out of MSB (ADD/SUB); 0 for AND/OR.
REQ-013 Port: zero  output  1  high when result == 0; updated together with result.

Function
REQ-014 Block SHALL be bit-serial: one result bit per clock, LSB first, through a single 1-bit slice (AND/OR/full-adder) with a registered carry flip-flop.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; transitions IDLE->RUN on start=1, RUN->DONE after the WIDTH-th bit, DONE->IDLE unconditionally after one cycle.
REQ-016 Accepted start (edge E0, state IDLE) SHALL capture in1, in2, control, carryin into internal shift/hold registers and clear the bit counter.
REQ-017 Bit i (i = 0..WIDTH-1) SHALL be computed and stored at edge E(i+1); state DONE entered at edge E(WIDTH).
REQ-018 done SHALL be high for exactly the one cycle following E(WIDTH); total latency start-edge to done = WIDTH cycles.
REQ-019 Carry register initial value per op: ADD = captured carryin; SUB = 1 (carryin ignored); AND/OR = 0.
REQ-020 SUB SHALL compute in1 + ~in2 + 1 modulo 2^WIDTH; carryout = 1 means no borrow.
REQ-021 AND/OR SHALL compute bitwise result; carry register SHALL not change, carryout = 0.
REQ-022 result, carryout, zero SHALL update only at edge E(WIDTH) and hold until the next operation's E(WIDTH); intermediate partial bits SHALL not be visible on result.
REQ-023 start in RUN or DONE SHALL be ignored (no restart, no queuing); start held high continuously SHALL be accepted again on the first IDLE cycle.
REQ-024 Changes on in1, in2, control, carryin after E0 SHALL not affect the operation in progress.
REQ-025 Bit counter SHALL be ceil(log2(WIDTH)) bits wide minimum and SHALL not wrap within an operation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, carryout=0, zero=1, carry register and counter to 0, independent of clk.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no done pulse; first start after rst_n rises SHALL be accepted normally.
REQ-028 rst_n deassertion SHALL be synchronised externally; block SHALL not act on start in the same edge rst_n rises.

Verification (WIDTH=8)
REQ-029 ADD in1=0xFF in2=0x01 carryin=0 -> done 8 cycles after start edge, result=0x00, carryout=1, zero=1.
REQ-030 ADD in1=0x7F in2=0x00 carryin=1 -> result=0x80, carryout=0, zero=0.
REQ-031 SUB in1=0x05 in2=0x07 carryin=1 -> result=0xFE, carryout=0; SUB 0x07-0x05 -> 0x02, carryout=1.
REQ-032 AND 0xF0,0x3C -> 0x30 carryout=0; OR 0xF0,0x3C -> 0xFC carryout=0; back-to-back with start held high, each done pulse single-cycle.
REQ-033 start pulsed and in1/in2/control toggled during RUN -> ignored; result matches operands captured at E0; busy high exactly 8 cycles.
REQ-034 rst_n asserted at bit 4 of an ADD -> outputs immediately reset values, no done; subsequent ADD 0x12+0x34 -> 0x46.
